// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Sequence: inhibit the clock line, request-to-send, shift the byte on
// device-generated clock edges, sample the device acknowledge, then wait
// for the bus to go idle. Drives the shared pins open-drain through *_oe.
// Optional build macro PS2_TX_FILTER_EN adds a 4-sample glitch filter on
// the synchronized PS/2 clock before falling-edge detection.
//
// Handshake (valid/ready): a byte is transferred on a rising clk edge where
// tx_valid && tx_ready are both 1. tx_data must be stable on that edge.
// tx_ready is 0 for the whole transfer and during the done/error pulse
// cycle, so tx_valid held high while busy is ignored (no queueing).
module ps2_host_tx #(
  parameter int C_CLK_HZ     = 25000000,
  parameter int C_INHIBIT_US = 120,
  parameter int C_TIMEOUT_US = 15000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error,
  output logic [2:0] dbg_state
);

  localparam int N_INH = (C_CLK_HZ / 1000000) * C_INHIBIT_US;
  localparam int N_TO  = (C_CLK_HZ / 1000000) * C_TIMEOUT_US;
  localparam int INH_W = $clog2(N_INH + 1);
  localparam int TO_W  = $clog2(N_TO + 1);

  // Start bit goes out one cycle before the clock line is released.
  localparam logic [INH_W-1:0] INH_START = INH_W'(N_INH - 2);
  localparam logic [INH_W-1:0] INH_LAST  = INH_W'(N_INH - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(N_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_SHIFT     = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t            state_q;
  logic              tx_ready_q;
  logic              clk_oe_q;
  logic              data_oe_q;
  logic              busy_q;
  logic              done_q;
  logic              ack_ok_q;
  logic              error_q;
  logic              ack_bit_q;
  logic [9:0]        frame_q;
  logic [3:0]        bit_cnt_q;
  logic [INH_W-1:0]  inh_cnt_q;
  logic [TO_W-1:0]   to_cnt_q;

  logic              clk_s1_q, clk_s2_q;
  logic              data_s1_q, data_s2_q;
  logic              clk_prev_q;
  logic              clk_lvl;
  logic              fe;

  logic              parity_d;
  logic [9:0]        frame_d;

  // Frame shifted out after the start bit: 8 data bits LSB first, odd
  // parity, stop bit (1 = released line).
  assign parity_d = ~^tx_data;
  assign frame_d  = {1'b1, parity_d, tx_data};

  // Two-stage synchronizers for both pins; idle level of the bus is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      clk_s1_q  <= ps2_clk_i;
      clk_s2_q  <= clk_s1_q;
      data_s1_q <= ps2_data_i;
      data_s2_q <= data_s1_q;
    end
  end

`ifdef PS2_TX_FILTER_EN
  logic       filt_q;
  logic [1:0] filt_cnt_q;

  // Filtered clock follows the synchronized clock only after it has
  // disagreed with the filtered value for 4 consecutive samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= 2'd0;
    end else if (clk_s2_q == filt_q) begin
      filt_cnt_q <= 2'd0;
    end else if (filt_cnt_q == 2'd3) begin
      filt_q     <= clk_s2_q;
      filt_cnt_q <= 2'd0;
    end else begin
      filt_cnt_q <= filt_cnt_q + 2'd1;
    end
  end

  assign clk_lvl = filt_q;
`else
  assign clk_lvl = clk_s2_q;
`endif

  // Previous clock level for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_prev_q <= 1'b1;
    end else begin
      clk_prev_q <= clk_lvl;
    end
  end

  assign fe = clk_prev_q & ~clk_lvl;

  // Transfer state machine; every output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tx_ready_q <= 1'b0;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_ok_q   <= 1'b0;
      error_q    <= 1'b0;
      ack_bit_q  <= 1'b0;
      frame_q    <= '0;
      bit_cnt_q  <= 4'd0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
    end else begin
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      ack_ok_q <= 1'b0;

      if (state_q == S_IDLE) begin
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        busy_q    <= 1'b0;
        // Ready comes up one cycle after reset release or after done/error.
        if (!tx_ready_q) begin
          tx_ready_q <= 1'b1;
        end else if (tx_valid) begin
          frame_q    <= frame_d;
          tx_ready_q <= 1'b0;
          busy_q     <= 1'b1;
          clk_oe_q   <= 1'b1;
          inh_cnt_q  <= '0;
          state_q    <= S_INHIBIT;
        end
      end else if (state_q == S_INHIBIT) begin
        inh_cnt_q <= inh_cnt_q + INH_W'(1);
        if (inh_cnt_q == INH_START) begin
          data_oe_q <= 1'b1;
        end
        if (inh_cnt_q == INH_LAST) begin
          clk_oe_q <= 1'b0;
          to_cnt_q <= '0;
          state_q  <= S_REQ;
        end
      end else begin
        // Device-clocked phases share one edge-gap watchdog.
        if (fe) begin
          to_cnt_q <= '0;
        end else begin
          to_cnt_q <= to_cnt_q + TO_W'(1);
        end

        if (!fe && (to_cnt_q == TO_LAST)) begin
          error_q   <= 1'b1;
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end else begin
          case (state_q)
            S_REQ: begin
              if (fe) begin
                data_oe_q <= ~frame_q[0];
                bit_cnt_q <= 4'd1;
                state_q   <= S_SHIFT;
              end
            end
            S_SHIFT: begin
              // Edges 2..10: remaining data bits, parity, then stop.
              if (fe) begin
                data_oe_q <= ~frame_q[bit_cnt_q];
                bit_cnt_q <= bit_cnt_q + 4'd1;
                if (bit_cnt_q == 4'd9) begin
                  state_q <= S_ACK;
                end
              end
            end
            S_ACK: begin
              // Device pulls data low on the 11th edge to acknowledge.
              if (fe) begin
                ack_bit_q <= ~data_s2_q;
                state_q   <= S_WAIT_IDLE;
              end
            end
            S_WAIT_IDLE: begin
              if (clk_lvl && data_s2_q) begin
                done_q   <= 1'b1;
                ack_ok_q <= ack_bit_q;
                busy_q   <= 1'b0;
                state_q  <= S_IDLE;
              end
            end
            default: begin
              state_q <= S_IDLE;
            end
          endcase
        end
      end
    end
  end

  assign tx_ready    = tx_ready_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign ack_ok      = ack_ok_q;
  assign error       = error_q;
  assign dbg_state   = state_q;

endmodule
